pa1mantri_cdc_fifo: RTL and testbench
=====================================

# pa1mantri_cdc_fifo

8-entry × 8-bit FIFO built with asynchronous-FIFO architecture (Gray-coded pointers, two-flop pointer synchronizers), run from a single clock inside the Tiny Tapeout user-project wrapper. Write data enters on `ui_in`; read data leaves on `uo_out`. Control strobes and status flags use the bidirectional `uio` pins. The block is the top-level user project, and its ports follow the standard TT pinout.

## Interface
- `DEPTH`, 8: number of FIFO entries (power of two).
- `WIDTH`, 8: data width in bits.
- `PTR_W`, 4: pointer width, log2(`DEPTH`)+1; the extra bit is the wrap bit.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  TT design-select; ignored.
- `ui_in`  in  8  write data.
- `uio_in`  in  8  bit0 = `wr_en`, bit1 = `rd_en`; bits 7:2 ignored.
- `uo_out`  out  8  registered read data.
- `uio_out`  out  8  bit2 = `full`, bit3 = `empty`, bit4 = `overflow`, bit5 = `underflow`; bits 1:0 and 7:6 = 0.
- `uio_oe`  out  8  constant 8'b0011_1100.

## Operation
- Storage: 8×8 register array, no reset needed.
- Pointers: `wbin`/`rbin` are binary, `PTR_W` bits. `wgray`/`rgray` are registered Gray copies: gray = bin ^ (bin>>1).
- Synchronizers:
  - `wgray` passes through two flops (`wq1`→`wq2`) to the read side.
  - `rgray` passes through two flops (`rq1`→`rq2`) to the write side.
- `empty` = (`rgray` == `wq2`).
- `full` = (`wgray` == {~`rq2[3:2]`, `rq2[1:0]`}).
- Both flags are combinational from registers, hence pessimistic.
- Write: if `wr_en` && !`full`:
  - mem[`wbin[2:0]`] ← `ui_in`
  - `wbin`++, `wgray` updated.
- Write while `full`: data dropped, pointers unchanged, `overflow` ← 1 (sticky).
- Read: if `rd_en` && !`empty`:
  - `uo_out` ← mem[`rbin[2:0]`]
  - `rbin`++, `rgray` updated.
- Read while `empty`: `uo_out` holds its value, `underflow` ← 1 (sticky).
- Simultaneous `wr_en` and `rd_en`: each side is qualified independently by its own flag in the same cycle.
- Pointers wrap modulo 16; the data index wraps modulo 8.
- Reset values:
  - All pointers and synchronizer flops: 0.
  - `uo_out`: 0; `overflow`, `underflow`: 0.
  - Hence `empty` = 1 and `full` = 0 out of reset.
- Reset asserted mid-operation flushes the FIFO; contents become unreachable.

## Timing
- Write accepted at edge N:
  - `wq2` reflects it after edge N+2.
  - `empty` falls after edge N+2.
  - Earliest successful `rd_en` is sampled at edge N+3; data appears on `uo_out` immediately after that edge.
- Read accepted at edge M: `full` falls after edge M+2.
- `full` rises right after the write edge that fills the 8th slot; there is no sync delay on the local side.
- `empty` rises right after the read edge that drains the last visible entry.
- Read latency: 1 cycle from the `rd_en` sample to valid `uo_out`. `uo_out` is held until the next successful read.
- Sticky flags update on the same edge as the offending request and clear only by `rst`.

## Structure
- Shared package `cdc_fifo_pkg`: `DEPTH`, `WIDTH`, `PTR_W`, `bin2gray` function, `uio` bit-index constants, `UIO_OE` constant.
- One natural sub-module, `sync2`: a `PTR_W`-wide two-flop synchronizer with synchronous reset, instantiated twice.
- The top module holds the memory, pointers, flags and pin mapping.

## Test plan
- Reset: assert `rst` 2 cycles → `uo_out`=0x00, `uio_out`=0x08 (`empty` only), `uio_oe`=0x3C.
- Single transfer: write 0xA5 at edge N → `empty` low after N+2; `rd_en` at N+3 → `uo_out`=0xA5, `empty` high again.
- Fill and overflow:
  - Write 0x01..0x08 → `full` high immediately after the 8th write.
  - Write 0xFF → dropped, `overflow`=1.
  - Read all 8 → 0x01..0x08 in order, `full` clears 2 cycles after the first read.
- Underflow: `rd_en` on an empty FIFO → `uo_out` unchanged, `underflow`=1 and stays set until `rst`.
- Wrap-around: 20 write/read pairs of incrementing data, `wr_en` and `rd_en` both held high → every accepted byte returns in order, no flag errors, pointers wrap past 15.
- Mid-operation reset: 3 entries written, then `rst` → `empty`=1, `uo_out`=0; a following write/read of 0x3C returns 0x3C.

Source files
------------

// File: rtl/pa1mantri_cdc_fifo_pkg.sv
// Shared constants and helpers for the Gray-pointer FIFO.
// Pin-level bit positions on the TT uio bus live here so the top and bench agree.
package cdc_fifo_pkg;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned PTR_W  = 4;
   localparam int unsigned ADDR_W = PTR_W - 1;

   localparam int unsigned UIO_WR_EN     = 0;
   localparam int unsigned UIO_RD_EN     = 1;
   localparam int unsigned UIO_FULL      = 2;
   localparam int unsigned UIO_EMPTY     = 3;
   localparam int unsigned UIO_OVERFLOW  = 4;
   localparam int unsigned UIO_UNDERFLOW = 5;

   localparam logic [7:0] UIO_OE = 8'b0011_1100;

   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/pa1mantri_cdc_fifo_sync2.sv
// Two-flop pointer synchronizer with synchronous active-high reset.
module sync2 #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q1_q, q1_d;
   logic [W-1:0] q2_q, q2_d;

   always_comb begin
      q1_d = d;
      q2_d = q1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q1_q <= '0;
         q2_q <= '0;
      end else begin
         q1_q <= q1_d;
         q2_q <= q2_d;
      end
   end

   assign q = q2_q;

endmodule

// File: rtl/pa1mantri_cdc_fifo.sv
// Tiny Tapeout top: 8x8 FIFO with Gray-coded pointers crossing through two-flop
// synchronizers, kept on a single clock so flags are conservatively late.
module pa1mantri_cdc_fifo
   import cdc_fifo_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wbin_q,  wbin_d;
   logic [PTR_W-1:0] rbin_q,  rbin_d;
   logic [PTR_W-1:0] wgray_q, wgray_d;
   logic [PTR_W-1:0] rgray_q, rgray_d;
   logic [PTR_W-1:0] wq2, rq2;

   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             overflow_q,  overflow_d;
   logic             underflow_q, underflow_d;

   logic wr_en, rd_en;
   logic full, empty;
   logic wr_fire, rd_fire;

   wire unused_inputs = &{1'b0, ena, uio_in[7:2]};

   assign wr_en = uio_in[UIO_WR_EN];
   assign rd_en = uio_in[UIO_RD_EN];

   sync2 #(.W(PTR_W)) u_sync_w2r (
      .clk (clk),
      .rst (rst),
      .d   (wgray_q),
      .q   (wq2)
   );

   sync2 #(.W(PTR_W)) u_sync_r2w (
      .clk (clk),
      .rst (rst),
      .d   (rgray_q),
      .q   (rq2)
   );

   // Full compares against the read pointer with its top two Gray bits inverted,
   // i.e. exactly one lap ahead.
   always_comb begin
      full    = (wgray_q == {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]});
      empty   = (rgray_q == wq2);
      wr_fire = wr_en && !full;
      rd_fire = rd_en && !empty;

      wbin_d      = wbin_q;
      rbin_d      = rbin_q;
      rdata_d     = rdata_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_fire) begin
         wbin_d = wbin_q + PTR_W'(1);
      end else if (wr_en) begin
         overflow_d = 1'b1;
      end

      if (rd_fire) begin
         rbin_d  = rbin_q + PTR_W'(1);
         rdata_d = mem_q[rbin_q[ADDR_W-1:0]];
      end else if (rd_en) begin
         underflow_d = 1'b1;
      end

      wgray_d = bin2gray(wbin_d);
      rgray_d = bin2gray(rbin_d);
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wbin_q[ADDR_W-1:0]] <= ui_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wbin_q      <= '0;
         rbin_q      <= '0;
         wgray_q     <= '0;
         rgray_q     <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wbin_q      <= wbin_d;
         rbin_q      <= rbin_d;
         wgray_q     <= wgray_d;
         rgray_q     <= rgray_d;
         rdata_q     <= rdata_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_comb begin
      uio_out                = '0;
      uio_out[UIO_FULL]      = full;
      uio_out[UIO_EMPTY]     = empty;
      uio_out[UIO_OVERFLOW]  = overflow_q;
      uio_out[UIO_UNDERFLOW] = underflow_q;
   end

   assign uo_out = rdata_q;
   assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_pa1mantri_cdc_fifo.sv
// Directed self-checking bench for the Gray-pointer FIFO top.
module tb_pa1mantri_cdc_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic       wr = 1'b0;
   logic       rd = 1'b0;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int errors = 0;
   int checks = 0;

   assign uio_in = {6'b0, rd, wr};

   always #5 clk = ~clk;

   pa1mantri_cdc_fifo dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr = 1'b0; rd = 1'b0;
      step(); step();
      rst = 1'b0;
      checks++;
      if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out got=%h exp=%h", uo_out, 8'h00); end
      checks++;
      if (uio_out !== 8'h08) begin errors++; $display("FAIL reset_uio_out got=%h exp=%h", uio_out, 8'h08); end
      checks++;
      if (uio_oe !== 8'h3C) begin errors++; $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, 8'h3C); end
   endtask

   task automatic test_single();
      ui_in = 8'hA5; wr = 1'b1;
      step();
      wr = 1'b0;
      checks++;
      if (uio_out[3] !== 1'b1) begin errors++; $display("FAIL single_empty_n got=%b exp=1", uio_out[3]); end
      step();
      checks++;
      if (uio_out[3] !== 1'b1) begin errors++; $display("FAIL single_empty_n1 got=%b exp=1", uio_out[3]); end
      step();
      checks++;
      if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL single_empty_n2 got=%b exp=0", uio_out[3]); end
      rd = 1'b1;
      step();
      rd = 1'b0;
      checks++;
      if (uo_out !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=%h", uo_out, 8'hA5); end
      checks++;
      if (uio_out !== 8'h08) begin errors++; $display("FAIL single_flags got=%h exp=%h", uio_out, 8'h08); end
   endtask

   task automatic test_fill_overflow();
      for (int i = 1; i <= 8; i++) begin
         ui_in = 8'(i); wr = 1'b1;
         step();
         if (i == 7) begin
            checks++;
            if (uio_out[2] !== 1'b0) begin errors++; $display("FAIL fill_full_at7 got=%b exp=0", uio_out[2]); end
         end
      end
      checks++;
      if (uio_out[2] !== 1'b1) begin errors++; $display("FAIL fill_full_at8 got=%b exp=1", uio_out[2]); end
      checks++;
      if (uio_out[4] !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got=%b exp=0", uio_out[4]); end
      ui_in = 8'hFF;
      step();
      wr = 1'b0;
      checks++;
      if (uio_out[4] !== 1'b1) begin errors++; $display("FAIL overflow_set got=%b exp=1", uio_out[4]); end
      checks++;
      if (uio_out[2] !== 1'b1) begin errors++; $display("FAIL overflow_full got=%b exp=1", uio_out[2]); end
      rd = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         checks++;
         if (uo_out !== 8'(i)) begin errors++; $display("FAIL drain_data%0d got=%h exp=%h", i, uo_out, 8'(i)); end
         if (i <= 3) begin
            checks++;
            if (uio_out[2] !== (i < 3)) begin errors++; $display("FAIL drain_full%0d got=%b exp=%b", i, uio_out[2], (i < 3)); end
         end
      end
      rd = 1'b0;
      checks++;
      if (uio_out[3] !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b exp=1", uio_out[3]); end
   endtask

   task automatic test_underflow();
      rd = 1'b1;
      step();
      rd = 1'b0;
      checks++;
      if (uo_out !== 8'h08) begin errors++; $display("FAIL underflow_hold got=%h exp=%h", uo_out, 8'h08); end
      checks++;
      if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL underflow_set got=%b exp=1", uio_out[5]); end
      step(); step(); step();
      checks++;
      if (uio_out[5] !== 1'b1) begin errors++; $display("FAIL underflow_sticky got=%b exp=1", uio_out[5]); end
   endtask

   task automatic test_mid_reset();
      wr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ui_in = 8'h90 + 8'(i);
         step();
      end
      wr = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (uio_out !== 8'h08) begin errors++; $display("FAIL midrst_flags got=%h exp=%h", uio_out, 8'h08); end
      checks++;
      if (uo_out !== 8'h00) begin errors++; $display("FAIL midrst_uo got=%h exp=%h", uo_out, 8'h00); end
      ui_in = 8'h3C; wr = 1'b1;
      step();
      wr = 1'b0;
      step(); step();
      checks++;
      if (uio_out[3] !== 1'b0) begin errors++; $display("FAIL midrst_visible got=%b exp=0", uio_out[3]); end
      rd = 1'b1;
      step();
      rd = 1'b0;
      checks++;
      if (uo_out !== 8'h3C) begin errors++; $display("FAIL midrst_data got=%h exp=%h", uo_out, 8'h3C); end
      checks++;
      if (uio_out[3] !== 1'b1) begin errors++; $display("FAIL midrst_empty got=%b exp=1", uio_out[3]); end
   endtask

   task automatic test_wrap();
      logic [7:0] seen [32];
      int         seen_at [32];
      int         n = 0;
      logic [7:0] prev;
      prev = uo_out;
      rd = 1'b1;
      for (int e = 0; e < 30; e++) begin
         wr = (e < 20);
         ui_in = 8'h40 + 8'(e);
         step();
         if (uo_out !== prev && n < 32) begin
            seen[n] = uo_out;
            seen_at[n] = e;
            n++;
            prev = uo_out;
         end
      end
      wr = 1'b0; rd = 1'b0;
      checks++;
      if (n !== 20) begin errors++; $display("FAIL wrap_count got=%0d exp=20", n); end
      for (int i = 0; i < 20 && i < n; i++) begin
         checks++;
         if (seen[i] !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_data%0d got=%h exp=%h", i, seen[i], 8'h40 + 8'(i)); end
      end
      if (n > 0) begin
         checks++;
         if (seen_at[0] !== 3) begin errors++; $display("FAIL wrap_first_edge got=%0d exp=3", seen_at[0]); end
      end
      if (n == 20) begin
         checks++;
         if (seen_at[19] !== 22) begin errors++; $display("FAIL wrap_last_edge got=%0d exp=22", seen_at[19]); end
      end
      checks++;
      if (uio_out[4:2] !== 3'b010) begin errors++; $display("FAIL wrap_flags got=%b exp=010", uio_out[4:2]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_overflow();
      test_underflow();
      test_mid_reset();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
